// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, constants and round-robin helper for dmem_arbiter
package dmem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int WORD_BYTES = 4;

    function automatic int rr_next(input int last, input int n);
        return (last + 1 >= n) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin one-hot grant starting after last_grant
module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        logic             found;
        grant_o = '0;
        found   = 1'b0;
        idx     = IDX_W'(rr_next(int'(last_grant_i), NUM_REQ));
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
            idx = IDX_W'(rr_next(int'(idx), NUM_REQ));
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin single-port data memory arbiter with lock and lock timeout
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 32,
    parameter int DEPTH_WORDS  = 64,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ-1:0]             req_we_i,
    input  logic [NUM_REQ-1:0]             req_lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_addr_i,
    input  logic [NUM_REQ*32-1:0]          req_wdata_i,
    input  logic [NUM_REQ*4-1:0]           req_be_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [31:0]                    rsp_rdata_o,
    output logic                           rsp_err_o,
    output logic                           lock_abort_o,
    output logic                           mem_we_o,
    output logic [3:0]                     mem_be_o,
    output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                    mem_wdata_o,
    input  logic [31:0]                    mem_rdata_i
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MEM_AW = $clog2(DEPTH_WORDS);
    localparam int OFS    = $clog2(WORD_BYTES);
    localparam int CNT_W  = $clog2(LOCK_TIMEOUT + 1);

    arb_state_e         r_state, w_state_nx;
    logic [IDX_W-1:0]   r_last_grant, r_owner, w_owner_nx, w_gidx;
    logic [CNT_W-1:0]   r_lock_cnt, w_cnt_nx;
    logic               r_lock_abort, w_abort_nx;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic               r_rsp_err, r_rsp_read;

    logic [NUM_REQ-1:0] w_eligible, w_grant;
    logic               w_accept, w_in_range, w_sel_we, w_sel_lock;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [3:0]         w_sel_be;

    // While locked only the owner may compete; nothing is granted during reset.
    always_comb begin
        w_eligible = req_valid_i;
        if (r_state == LOCKED) begin
            w_eligible = req_valid_i & (NUM_REQ'(1) << r_owner);
        end
        if (reset_i) begin
            w_eligible = '0;
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .valid_i      (w_eligible),
        .last_grant_i (r_last_grant),
        .grant_o      (w_grant)
    );

    always_comb begin
        w_gidx      = '0;
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx      = IDX_W'(i);
                w_sel_we    = req_we_i[i];
                w_sel_lock  = req_lock_i[i];
                w_sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata_i[i*32 +: 32];
                w_sel_be    = req_be_i[i*4 +: 4];
            end
        end
    end

    assign w_accept   = |w_grant;
    assign w_in_range = (w_sel_addr >> OFS) < ADDR_W'(DEPTH_WORDS);

    assign req_ready_o = w_grant;
    assign mem_we_o    = w_accept & w_sel_we & w_in_range;
    assign mem_be_o    = w_accept ? w_sel_be : 4'b0000;
    assign mem_addr_o  = w_accept ? w_sel_addr[OFS +: MEM_AW] : '0;
    assign mem_wdata_o = w_accept ? w_sel_wdata : 32'd0;

    // An owner acceptance wins over a timeout landing in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_cnt_nx   = r_lock_cnt;
        w_abort_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_sel_lock) begin
                    w_state_nx = LOCKED;
                    w_owner_nx = w_gidx;
                    w_cnt_nx   = '0;
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    w_cnt_nx = '0;
                    if (!w_sel_lock) begin
                        w_state_nx = IDLE;
                    end
                end else if (r_lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_abort_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_lock_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_lock_cnt   <= '0;
            r_lock_abort <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_read   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_owner      <= w_owner_nx;
            r_lock_cnt   <= w_cnt_nx;
            r_lock_abort <= w_abort_nx;
            if (w_accept) begin
                r_last_grant <= w_gidx;
            end
            r_rsp_valid <= (w_accept && (!w_sel_we || !w_in_range)) ? w_grant : '0;
            r_rsp_err   <= w_accept & !w_in_range;
            r_rsp_read  <= w_accept & !w_sel_we & w_in_range;
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_err_o    = r_rsp_err;
    assign rsp_rdata_o  = (r_rsp_read && !reset_i) ? mem_rdata_i : 32'd0;
    assign lock_abort_o = r_lock_abort;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int TMO   = 16;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N-1:0]    req_valid_i, req_ready_o, req_we_i, req_lock_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N*32-1:0] req_wdata_i;
    logic [N*4-1:0]  req_be_i;
    logic [N-1:0]    rsp_valid_o;
    logic [31:0]     rsp_rdata_o;
    logic            rsp_err_o, lock_abort_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [5:0]      mem_addr_o;
    logic [31:0]     mem_wdata_o, mem_rdata_i;

    logic            load_mem;
    logic [31:0]     mem     [DEPTH];
    logic [31:0]     ref_mem [DEPTH];
    int              n_checks = 0;
    int              n_pass   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_REQ      (N),
        .ADDR_W       (AW),
        .DEPTH_WORDS  (DEPTH),
        .LOCK_TIMEOUT (TMO)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_lock_i   (req_lock_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .lock_abort_o (lock_abort_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
    endfunction

    // Memory macro: synchronous byte-enabled write, registered read.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
        mem_rdata_i <= mem[mem_addr_o];
    end

    task automatic set_req(input int p, input logic v, input logic we, input logic lk,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid_i[p]          = v;
        req_we_i[p]             = we;
        req_lock_i[p]           = lk;
        req_addr_i[p*AW +: AW]  = a;
        req_wdata_i[p*32 +: 32] = d;
        req_be_i[p*4 +: 4]      = be;
    endtask

    task automatic idle_all();
        req_valid_i = '0;
        req_we_i    = '0;
        req_lock_i  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        idle_all();
        step();
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        load_mem = 1'b1;
        reset_i  = 1'b1;
        idle_all();
        step();
        load_mem = 1'b0;
        step();
        look();
        n_checks++; if (req_ready_o !== 2'b00) $display("FAIL reset_ready got %b want 00", req_ready_o); else n_pass++;
        n_checks++; if (rsp_valid_o !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid_o); else n_pass++;
        n_checks++; if (rsp_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", rsp_err_o); else n_pass++;
        n_checks++; if (rsp_rdata_o !== 32'd0) $display("FAIL reset_rdata got %h want 0", rsp_rdata_o); else n_pass++;
        n_checks++; if (lock_abort_o !== 1'b0) $display("FAIL reset_abort got %b want 0", lock_abort_o); else n_pass++;
        n_checks++; if (mem_we_o !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we_o); else n_pass++;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
        step();
        reset_i = 1'b0;
        idle_all();
        look();
        n_checks++; if (rsp_valid_o !== 2'b00) $display("FAIL reset_cycle_read got %b want 00", rsp_valid_o); else n_pass++;
        step();
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready_o); else n_pass++;
        n_checks++; if (mem_addr_o !== 6'd4) $display("FAIL single_addr got %0d want 4", mem_addr_o); else n_pass++;
        n_checks++; if (mem_we_o !== 1'b0) $display("FAIL single_we got %b want 0", mem_we_o); else n_pass++;
        step();
        idle_all();
        look();
        n_checks++; if (rsp_valid_o !== 2'b01) $display("FAIL single_rsp_valid got %b want 01", rsp_valid_o); else n_pass++;
        n_checks++; if (rsp_rdata_o !== 32'hDEADBEEF) $display("FAIL single_rdata got %h want deadbeef", rsp_rdata_o); else n_pass++;
        n_checks++; if (rsp_err_o !== 1'b0) $display("FAIL single_err got %b want 0", rsp_err_o); else n_pass++;
        step();
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 4'hF);
            set_req(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 4'hF);
            look();
            exp = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (req_ready_o !== exp) $display("FAIL contention_ready c%0d got %b want %b", c, req_ready_o, exp); else n_pass++;
            if (c > 0) begin
                exp = (c % 2 == 1) ? 2'b01 : 2'b10;
                n_checks++; if (rsp_valid_o !== exp) $display("FAIL contention_rsp c%0d got %b want %b", c, rsp_valid_o, exp); else n_pass++;
            end
            step();
        end
        idle_all();
        look();
        n_checks++; if (rsp_valid_o !== 2'b10) $display("FAIL contention_last_rsp got %b want 10", rsp_valid_o); else n_pass++;
        step();
    endtask

    task automatic test_lock();
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL lock_pre_ready got %b want 01", req_ready_o); else n_pass++;
        step();
        set_req(1, 1'b1, 1'b0, 1'b1, 32'hC, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b10) $display("FAIL lock_acquire_ready got %b want 10", req_ready_o); else n_pass++;
        step();
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 4'h0);
        look();
        n_checks++; if (req_ready_o !== 2'b00) $display("FAIL lock_block1 got %b want 00", req_ready_o); else n_pass++;
        n_checks++; if (rsp_valid_o !== 2'b10) $display("FAIL lock_rsp got %b want 10", rsp_valid_o); else n_pass++;
        n_checks++; if (rsp_rdata_o !== ref_mem[3]) $display("FAIL lock_rdata got %h want %h", rsp_rdata_o, ref_mem[3]); else n_pass++;
        step();
        look();
        n_checks++; if (req_ready_o !== 2'b00) $display("FAIL lock_block2 got %b want 00", req_ready_o); else n_pass++;
        step();
        set_req(1, 1'b1, 1'b1, 1'b0, 32'hC, 32'h12345678, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b10) $display("FAIL lock_release_ready got %b want 10", req_ready_o); else n_pass++;
        n_checks++; if (mem_we_o !== 1'b1) $display("FAIL lock_release_we got %b want 1", mem_we_o); else n_pass++;
        ref_mem[3] = 32'h12345678;
        step();
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 4'h0);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL lock_after_ready got %b want 01", req_ready_o); else n_pass++;
        step();
        idle_all();
    endtask

    task automatic test_timeout();
        int bad = 0;
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL timeout_lock_ready got %b want 01", req_ready_o); else n_pass++;
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 4'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);
        for (int c = 0; c < TMO; c++) begin
            look();
            if (req_ready_o !== 2'b00 || lock_abort_o !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL timeout_hold got %0d bad cycles want 0", bad); else n_pass++;
        look();
        n_checks++; if (lock_abort_o !== 1'b1) $display("FAIL timeout_abort got %b want 1", lock_abort_o); else n_pass++;
        n_checks++; if (req_ready_o !== 2'b10) $display("FAIL timeout_grant got %b want 10", req_ready_o); else n_pass++;
        step();
        idle_all();
        look();
        n_checks++; if (lock_abort_o !== 1'b0) $display("FAIL timeout_pulse_width got %b want 0", lock_abort_o); else n_pass++;
        step();
    endtask

    task automatic test_lock_priority();
        int bad = 0;
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL prio_lock_ready got %b want 01", req_ready_o); else n_pass++;
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 4'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);
        for (int c = 0; c < TMO - 1; c++) begin
            look();
            if (req_ready_o !== 2'b00 || lock_abort_o !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL prio_hold got %0d bad cycles want 0", bad); else n_pass++;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL prio_owner_ready got %b want 01", req_ready_o); else n_pass++;
        step();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 4'h0);
        look();
        n_checks++; if (lock_abort_o !== 1'b0) $display("FAIL prio_no_abort got %b want 0", lock_abort_o); else n_pass++;
        n_checks++; if (req_ready_o !== 2'b10) $display("FAIL prio_next_grant got %b want 10", req_ready_o); else n_pass++;
        step();
        idle_all();
        look();
        n_checks++; if (lock_abort_o !== 1'b0) $display("FAIL prio_no_abort_late got %b want 0", lock_abort_o); else n_pass++;
        step();
    endtask

    task automatic test_out_of_range();
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL oor_ready got %b want 01", req_ready_o); else n_pass++;
        n_checks++; if (mem_we_o !== 1'b0) $display("FAIL oor_we got %b want 0", mem_we_o); else n_pass++;
        step();
        idle_all();
        look();
        n_checks++; if (rsp_valid_o !== 2'b01) $display("FAIL oor_rsp_valid got %b want 01", rsp_valid_o); else n_pass++;
        n_checks++; if (rsp_err_o !== 1'b1) $display("FAIL oor_err got %b want 1", rsp_err_o); else n_pass++;
        n_checks++; if (rsp_rdata_o !== 32'd0) $display("FAIL oor_rdata got %h want 0", rsp_rdata_o); else n_pass++;
        step();
        n_checks++; if (mem[0] !== ref_mem[0]) $display("FAIL oor_mem0 got %h want %h", mem[0], ref_mem[0]); else n_pass++;
    endtask

    task automatic test_byte_write();
        logic [31:0] exp = (ref_mem[2] & 32'hFFFF00FF) | 32'h0000AB00;
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h8, 32'h0000AB00, 4'b0010);
        look();
        n_checks++; if (req_ready_o !== 2'b10) $display("FAIL bw_ready got %b want 10", req_ready_o); else n_pass++;
        n_checks++; if (mem_be_o !== 4'b0010) $display("FAIL bw_be got %b want 0010", mem_be_o); else n_pass++;
        n_checks++; if (mem_we_o !== 1'b1) $display("FAIL bw_we got %b want 1", mem_we_o); else n_pass++;
        step();
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0, 4'hF);
        look();
        n_checks++; if (rsp_valid_o !== 2'b00) $display("FAIL bw_write_rsp got %b want 00", rsp_valid_o); else n_pass++;
        step();
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 4'h0);
        look();
        n_checks++; if (rsp_valid_o !== 2'b10) $display("FAIL bw_read_rsp got %b want 10", rsp_valid_o); else n_pass++;
        n_checks++; if (rsp_rdata_o !== exp) $display("FAIL bw_rdata got %h want %h", rsp_rdata_o, exp); else n_pass++;
        ref_mem[2] = exp;
        step();
    endtask

    task automatic test_reset_mid_lock();
        int bad = 0;
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0, 4'hF);
        look();
        n_checks++; if (req_ready_o !== 2'b01) $display("FAIL midlock_ready got %b want 01", req_ready_o); else n_pass++;
        step();
        idle_all();
        repeat (3) step();
        reset_i = 1'b1;
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 4'hF);
        step();
        reset_i = 1'b0;
        look();
        n_checks++; if (req_ready_o !== 2'b10) $display("FAIL midlock_release got %b want 10", req_ready_o); else n_pass++;
        step();
        idle_all();
        for (int c = 0; c < TMO + 4; c++) begin
            look();
            if (lock_abort_o !== 1'b0) bad++;
            step();
        end
        n_checks++; if (bad !== 0) $display("FAIL midlock_abort got %0d pulses want 0", bad); else n_pass++;
    endtask

    task automatic test_random();
        logic        pv [N];
        logic        pwe[N];
        logic        plk[N];
        logic [31:0] pa [N];
        logic [31:0] pd [N];
        logic [3:0]  pbe[N];
        int          m_last = N - 1;
        logic        m_locked = 1'b0;
        int          m_owner = 0;
        int          m_idle = 0;
        logic [N-1:0] exp_rv = '0;
        logic        exp_err = 1'b0;
        logic [31:0] exp_rd = '0;
        logic        exp_ab = 1'b0;
        logic [N-1:0] exp_ready;
        logic        in_rng, exp_we, go;
        int          g, idx, w, bad_words;
        for (int p = 0; p < N; p++) pv[p] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < N; p++) begin
                go = (m_locked && p == m_owner) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
                if (!pv[p] && go) begin
                    pv[p]  = 1'b1;
                    pwe[p] = 1'($urandom_range(0, 1));
                    plk[p] = ($urandom_range(0, 3) == 0);
                    pa[p]  = (32'($urandom_range(0, 79)) << 2) | 32'($urandom_range(0, 3));
                    pd[p]  = $urandom;
                    pbe[p] = 4'($urandom_range(0, 15));
                end
                set_req(p, pv[p], pwe[p], plk[p], pa[p], pd[p], pbe[p]);
            end
            g = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && pv[idx] && (!m_locked || idx == m_owner)) g = idx;
            end
            exp_ready = (g >= 0) ? (N'(1) << g) : '0;
            in_rng    = (g >= 0) && ((pa[g] >> 2) < DEPTH);
            exp_we    = (g >= 0) && pwe[g] && in_rng;
            look();
            n_checks++; if (req_ready_o !== exp_ready) $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, req_ready_o, exp_ready); else n_pass++;
            n_checks++; if (mem_we_o !== exp_we) $display("FAIL rnd_we cyc%0d got %b want %b", cyc, mem_we_o, exp_we); else n_pass++;
            if (g >= 0) begin
                n_checks++; if (mem_addr_o !== pa[g][7:2]) $display("FAIL rnd_addr cyc%0d got %h want %h", cyc, mem_addr_o, pa[g][7:2]); else n_pass++;
                n_checks++; if (mem_be_o !== pbe[g]) $display("FAIL rnd_be cyc%0d got %b want %b", cyc, mem_be_o, pbe[g]); else n_pass++;
                n_checks++; if (mem_wdata_o !== pd[g]) $display("FAIL rnd_wdata cyc%0d got %h want %h", cyc, mem_wdata_o, pd[g]); else n_pass++;
            end
            n_checks++; if (rsp_valid_o !== exp_rv) $display("FAIL rnd_rsp_valid cyc%0d got %b want %b", cyc, rsp_valid_o, exp_rv); else n_pass++;
            if (exp_rv != '0) begin
                n_checks++; if (rsp_err_o !== exp_err) $display("FAIL rnd_err cyc%0d got %b want %b", cyc, rsp_err_o, exp_err); else n_pass++;
                n_checks++; if (rsp_rdata_o !== exp_rd) $display("FAIL rnd_rdata cyc%0d got %h want %h", cyc, rsp_rdata_o, exp_rd); else n_pass++;
            end
            n_checks++; if (lock_abort_o !== exp_ab) $display("FAIL rnd_abort cyc%0d got %b want %b", cyc, lock_abort_o, exp_ab); else n_pass++;
            exp_rv  = '0;
            exp_err = 1'b0;
            exp_rd  = '0;
            exp_ab  = 1'b0;
            if (g >= 0) begin
                w = int'(pa[g] >> 2);
                if (!in_rng) begin
                    exp_rv  = N'(1) << g;
                    exp_err = 1'b1;
                end else if (!pwe[g]) begin
                    exp_rv = N'(1) << g;
                    exp_rd = ref_mem[w];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (pbe[g][b]) ref_mem[w][b*8 +: 8] = pd[g][b*8 +: 8];
                end
                m_last = g;
                pv[g]  = 1'b0;
                if (!m_locked) begin
                    if (plk[g]) begin
                        m_locked = 1'b1;
                        m_owner  = g;
                        m_idle   = 0;
                    end
                end else begin
                    m_idle = 0;
                    if (!plk[g]) m_locked = 1'b0;
                end
            end else if (m_locked) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_locked = 1'b0;
                    m_idle   = 0;
                    exp_ab   = 1'b1;
                end
            end
            step();
        end
        idle_all();
        step();
        bad_words = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        n_checks++; if (bad_words !== 0) $display("FAIL rnd_mem_contents got %0d differing words want 0", bad_words); else n_pass++;
    endtask

    initial begin
        reset_i     = 1'b1;
        load_mem    = 1'b1;
        req_valid_i = '0;
        req_we_i    = '0;
        req_lock_i  = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_timeout();
        test_lock_priority();
        test_out_of_range();
        test_byte_write();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port, word-addressed data memory between NUM_REQ requesters: port 0 is the core load/store unit; higher ports serve secondary masters such as debug or DMA.
- Performs round-robin arbitration with a valid/ready request handshake and a fixed 1-cycle read response.
- Provides a lock mechanism so the atomic (A-extension) unit can hold the memory across a read-modify-write pair.
- Sits between the requesters and the memory macro, which has a synchronous write and a registered read.

Parameters:
- NUM_REQ, 2, number of requester ports (2..4).
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 64, number of 32-bit words implemented in the memory.
- LOCK_TIMEOUT, 16, number of idle owner cycles after which a held lock is forcibly released.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  request valid, one bit per requester.
- req_ready_o  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_lock_i  in  NUM_REQ  acquire or keep the lock after this access.
- req_addr_i  in  NUM_REQ*ADDR_W  byte address; bits [1:0] ignored.
- req_wdata_i  in  NUM_REQ*32  write data.
- req_be_i  in  NUM_REQ*4  byte enables.
- rsp_valid_o  out  NUM_REQ  read response valid, or error response valid.
- rsp_rdata_o  out  32  read data, shared by all ports and qualified by rsp_valid_o.
- rsp_err_o  out  1  out-of-range access, qualified by rsp_valid_o.
- lock_abort_o  out  1  single-cycle pulse when a lock is released by timeout.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  $clog2(DEPTH_WORDS)  word index.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid the cycle after the address is presented.

Behaviour:
- Reset, synchronous:
  - All outputs are 0.
  - state = IDLE.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
  - Lock counter and response registers are cleared.
  - A read accepted in the cycle reset is asserted produces no response.
- Handshake:
  - A requester holds valid and all fields stable until it sees ready.
  - Acceptance occurs when valid & ready are both high in the same cycle.
  - At most one acceptance per cycle.
  - Back-to-back acceptances are allowed, giving 1 access per cycle of throughput.
- Arbitration in IDLE:
  - req_ready_o is combinational.
  - Grant the first valid requester searching round-robin from last_grant+1.
  - last_grant updates on each acceptance.
- Memory drive: in the acceptance cycle, mem_addr_o = granted addr[2+:log2 DEPTH], mem_wdata_o = granted wdata, mem_be_o = granted be. When there is no acceptance, mem_we_o = 0.
- Range check:
  - An access is out of range if addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - For an out-of-range access, mem_we_o is forced to 0.
  - The request is still accepted.
  - The response, read or write, has rsp_err_o = 1 and rsp_rdata_o = 0.
- Responses, latency exactly 1 cycle after acceptance:
  - In-range read: rsp_valid_o[g] = 1 with rsp_rdata_o = mem_rdata_i.
  - In-range write: no response.
  - Out-of-range read or write: error response as above.
- Lock:
  - Accepting a request with req_lock_i = 1 enters LOCKED with owner = g.
  - In LOCKED, only the owner can be granted; all others see ready = 0.
  - An owner request with lock = 0 is accepted and returns the arbiter to IDLE.
  - An owner request with lock = 1 keeps LOCKED and resets the idle counter.
- Lock timeout:
  - In LOCKED, the idle counter increments on each cycle without an owner acceptance.
  - When the counter reaches LOCK_TIMEOUT, the arbiter returns to IDLE and lock_abort_o pulses for 1 cycle.
  - The counter clears on IDLE entry.
- FSM transitions:
  - IDLE -> LOCKED on a locked acceptance.
  - LOCKED -> IDLE on an unlocking acceptance or on timeout.
- Simultaneous events: an owner acceptance in the same cycle the counter would reach timeout takes priority, so the timeout does not fire.
- Reset mid-lock: the arbiter releases unconditionally and lock_abort_o does not pulse.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_e {IDLE, LOCKED}.
  - Constant WORD_BYTES = 4.
  - Function for the round-robin next index.
- Sub-module rr_picker: a combinational round-robin one-hot grant from valid vector and last_grant.
- Top level holds the FSM, lock counter, response registers and the memory mux.

Test Plan:
- Single read: port0 reads 0x10 with mem[4] = 0xDEADBEEF -> ready0 in cycle N; rsp_valid_o = 01 with rdata = 0xDEADBEEF in N+1.
- Contention: both ports valid for 4 cycles after reset -> grant order 0, 1, 0, 1; ready is never 11.
- Lock: port1 reads with lock = 1 while port0 is valid -> port0 gets ready = 0 until port1 writes with lock = 0 at cycle +3; port0 is granted the next cycle.
- Timeout: port0 locks, then idles 16 cycles while port1 is valid -> lock_abort_o pulses once; port1 is granted on the following cycle.
- Out of range: port0 writes to address 0x100 with DEPTH_WORDS = 64 -> mem_we_o stays 0; rsp_valid_o[0] = 1 and rsp_err_o = 1 in N+1; memory contents unchanged.
- Byte write: port1 writes be = 0010, wdata = 0x0000AB00 to 0x8, then reads 0x8 -> mem_be_o = 0010; read returns the old word with only byte 1 = 0xAB.
